// File: rtl/wave_read_arbiter_pkg.sv
// Shared types for the wave BRAM read arbiter: requester ids, the read tag
// that travels alongside each BRAM access, and the saturating stat increment.
package wave_arb_pkg;

  localparam int STAT_WIDTH     = 16;
  localparam int OSC_SLOT_WIDTH = 8;

  typedef enum logic [1:0] {
    REQ_OSC = 2'd0,
    REQ_VIZ = 2'd1,
    REQ_DBG = 2'd2
  } req_id_t;

  typedef struct packed {
    logic                      valid;
    req_id_t                   id;
    logic [OSC_SLOT_WIDTH-1:0] slot;
    logic                      zero_flag;
  } rd_tag_t;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/wave_read_arbiter_if.sv
// Read-side bus of the wave sample BRAM; the arbiter is the master.
interface wave_read_arbiter_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WW_WIDTH     = 15
);
  logic                    en;
  logic [WW_WIDTH-1:0]     addr;
  logic [SAMPLE_WIDTH-1:0] data;

  modport master (output en, output addr, input data);
  modport slave  (input en, input addr, output data);
endinterface

// File: rtl/wave_read_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of read tags, aligning each tag with the BRAM
// data it describes; a synchronous flush drops everything in flight.
module rd_tag_pipe
  import wave_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk_i,
  input  logic    flush_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] pipe_q;
  rd_tag_t [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/wave_read_arbiter.sv
// Time-slotted arbiter for the wave BRAM read port: fixed oscillator slots plus
// one round-robin viz/debug slot. Optional stat counters under ARB_STATS_EN.
module wave_read_arbiter
  import wave_arb_pkg::*;
#(
  parameter int NUM_OSCILLATORS = 4,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int WW_WIDTH        = 15,
  parameter int BRAM_LATENCY    = 2
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic [WW_WIDTH-1:0]                         wave_width_in,
  input  logic                                        load_busy_in,
  input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]    osc_index_in,
  output logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_sample_out,
  input  logic                                        viz_req_in,
  input  logic [WW_WIDTH-1:0]                         viz_index_in,
  output logic [SAMPLE_WIDTH-1:0]                     viz_sample_out,
  output logic                                        viz_valid_out,
  input  logic                                        dbg_req_in,
  input  logic [WW_WIDTH-1:0]                         dbg_index_in,
  output logic [SAMPLE_WIDTH-1:0]                     dbg_sample_out,
  output logic                                        dbg_valid_out,
`ifdef ARB_STATS_EN
  output logic [STAT_WIDTH-1:0]                       stat_viz_grants_out,
  output logic [STAT_WIDTH-1:0]                       stat_dbg_grants_out,
  output logic [STAT_WIDTH-1:0]                       stat_stall_slots_out,
`endif
  wave_read_arbiter_if.master                         bram
);

  localparam int SLOT_W = $clog2(NUM_OSCILLATORS + 1);
  localparam logic [SLOT_W-1:0] AUX_SLOT = SLOT_W'(NUM_OSCILLATORS);

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                viz_pend_q, viz_pend_d, dbg_pend_q, dbg_pend_d, rr_q, rr_d;
  logic [WW_WIDTH-1:0] viz_idx_q, viz_idx_d, dbg_idx_q, dbg_idx_d;
  logic                bram_en_q, bram_en_d;
  logic [WW_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0] osc_sample_q, osc_sample_d;
  logic [SAMPLE_WIDTH-1:0] viz_sample_q, viz_sample_d, dbg_sample_q, dbg_sample_d;
  logic                viz_valid_q, viz_valid_d, dbg_valid_q, dbg_valid_d;

  logic [WW_WIDTH-1:0]     sel_idx_s, issue_idx_s;
  logic                    issue_s, in_range_s, grant_viz_s, grant_dbg_s;
  req_id_t                 issue_id_s;
  rd_tag_t                 tag_in_s, tag_out_s;
  logic [SAMPLE_WIDTH-1:0] del_data_s;

  always_comb begin
    slot_d    = (slot_q == AUX_SLOT) ? '0 : slot_q + SLOT_W'(1);
    sel_idx_s = '0;
    for (int k = 0; k < NUM_OSCILLATORS; k++) begin
      sel_idx_s = (slot_q == SLOT_W'(k)) ? osc_index_in[k] : sel_idx_s;
    end
  end

  // Busy slots are simply lost: aux pending state and rr pointer are untouched.
  always_comb begin
    rr_d        = rr_q;
    grant_viz_s = 1'b0;
    grant_dbg_s = 1'b0;
    issue_s     = 1'b0;
    issue_id_s  = REQ_OSC;
    issue_idx_s = '0;
    if (load_busy_in) begin
      issue_s = 1'b0;
    end else if (slot_q != AUX_SLOT) begin
      issue_s     = 1'b1;
      issue_idx_s = sel_idx_s;
    end else if (viz_pend_q && (!dbg_pend_q || !rr_q)) begin
      grant_viz_s = 1'b1;
      issue_s     = 1'b1;
      issue_id_s  = REQ_VIZ;
      issue_idx_s = viz_idx_q;
      rr_d        = dbg_pend_q ? 1'b1 : rr_q;
    end else if (dbg_pend_q) begin
      grant_dbg_s = 1'b1;
      issue_s     = 1'b1;
      issue_id_s  = REQ_DBG;
      issue_idx_s = dbg_idx_q;
      rr_d        = viz_pend_q ? 1'b0 : rr_q;
    end else begin
      issue_s = 1'b0;
    end
  end

  // A fresh request in the grant cycle re-arms pending with its new index.
  always_comb begin
    viz_pend_d = viz_req_in | (viz_pend_q & ~grant_viz_s);
    viz_idx_d  = viz_req_in ? viz_index_in : viz_idx_q;
    dbg_pend_d = dbg_req_in | (dbg_pend_q & ~grant_dbg_s);
    dbg_idx_d  = dbg_req_in ? dbg_index_in : dbg_idx_q;
    in_range_s = issue_idx_s < wave_width_in;
    bram_en_d  = issue_s & in_range_s;
    bram_addr_d = bram_en_d ? issue_idx_s : bram_addr_q;
    tag_in_s.valid     = issue_s;
    tag_in_s.id        = issue_id_s;
    tag_in_s.slot      = OSC_SLOT_WIDTH'(slot_q);
    tag_in_s.zero_flag = ~in_range_s;
  end

  rd_tag_pipe #(.DEPTH(BRAM_LATENCY + 1)) u_tag_pipe (
    .clk_i   (clk_in),
    .flush_i (rst_in),
    .tag_i   (tag_in_s),
    .tag_o   (tag_out_s)
  );

  always_comb begin
    del_data_s   = tag_out_s.zero_flag ? '0 : bram.data;
    osc_sample_d = osc_sample_q;
    viz_sample_d = viz_sample_q;
    dbg_sample_d = dbg_sample_q;
    viz_valid_d  = 1'b0;
    dbg_valid_d  = 1'b0;
    if (tag_out_s.valid) begin
      case (tag_out_s.id)
        REQ_OSC: begin
          for (int k = 0; k < NUM_OSCILLATORS; k++) begin
            osc_sample_d[k] = (tag_out_s.slot == OSC_SLOT_WIDTH'(k)) ? del_data_s : osc_sample_q[k];
          end
        end
        REQ_VIZ: begin
          viz_sample_d = del_data_s;
          viz_valid_d  = 1'b1;
        end
        REQ_DBG: begin
          dbg_sample_d = del_data_s;
          dbg_valid_d  = 1'b1;
        end
        default: begin
          viz_valid_d = 1'b0;
        end
      endcase
    end else begin
      viz_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_q       <= '0;
      viz_pend_q   <= 1'b0;
      dbg_pend_q   <= 1'b0;
      rr_q         <= 1'b0;
      viz_idx_q    <= '0;
      dbg_idx_q    <= '0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      osc_sample_q <= '0;
      viz_sample_q <= '0;
      dbg_sample_q <= '0;
      viz_valid_q  <= 1'b0;
      dbg_valid_q  <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      viz_pend_q   <= viz_pend_d;
      dbg_pend_q   <= dbg_pend_d;
      rr_q         <= rr_d;
      viz_idx_q    <= viz_idx_d;
      dbg_idx_q    <= dbg_idx_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      osc_sample_q <= osc_sample_d;
      viz_sample_q <= viz_sample_d;
      dbg_sample_q <= dbg_sample_d;
      viz_valid_q  <= viz_valid_d;
      dbg_valid_q  <= dbg_valid_d;
    end
  end

  assign bram.en        = bram_en_q;
  assign bram.addr      = bram_addr_q;
  assign osc_sample_out = osc_sample_q;
  assign viz_sample_out = viz_sample_q;
  assign viz_valid_out  = viz_valid_q;
  assign dbg_sample_out = dbg_sample_q;
  assign dbg_valid_out  = dbg_valid_q;

`ifdef ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_viz_q, stat_dbg_q, stat_stall_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_viz_q   <= '0;
      stat_dbg_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_viz_q   <= grant_viz_s  ? sat_inc(stat_viz_q)   : stat_viz_q;
      stat_dbg_q   <= grant_dbg_s  ? sat_inc(stat_dbg_q)   : stat_dbg_q;
      stat_stall_q <= load_busy_in ? sat_inc(stat_stall_q) : stat_stall_q;
    end
  end

  assign stat_viz_grants_out  = stat_viz_q;
  assign stat_dbg_grants_out  = stat_dbg_q;
  assign stat_stall_slots_out = stat_stall_q;
`endif

endmodule

// File: doc/wave_read_arbiter.md
Name: wave_read_arbiter

Overview:
Time-multiplexes the single read port of the wave sample BRAM among NUM_OSCILLATORS oscillators, the HDMI visualizer and the UART byte-screen debugger. It sits between the oscillator bank and debug/viz consumers on one side and the wave loader's BRAM on the other. Oscillators get guaranteed fixed slots; viz and debug share one round-robin auxiliary slot. It stalls reads while the loader rewrites the BRAM.

Parameters:
NUM_OSCILLATORS, 4, number of oscillator read slots
SAMPLE_WIDTH, 16, BRAM word width
WW_WIDTH, 15, address/index width
BRAM_LATENCY, 2, cycles from bram_en_out asserted to valid bram_data_in

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
wave_width_in  in  WW_WIDTH  current wave length; valid indices are 0..wave_width_in-1
load_busy_in  in  1  loader owns the BRAM; issue no reads
osc_index_in  in  NUM_OSCILLATORS x WW_WIDTH  per-oscillator sample index
osc_sample_out  out  NUM_OSCILLATORS x SAMPLE_WIDTH  per-oscillator registered sample
viz_req_in  in  1  one-cycle viz read request
viz_index_in  in  WW_WIDTH  viz index, sampled with viz_req_in
viz_sample_out  out  SAMPLE_WIDTH  viz result
viz_valid_out  out  1  one-cycle pulse; viz_sample_out updated
dbg_req_in  in  1  one-cycle debug read request
dbg_index_in  in  WW_WIDTH  debug index, sampled with dbg_req_in
dbg_sample_out  out  SAMPLE_WIDTH  debug result
dbg_valid_out  out  1  one-cycle pulse; dbg_sample_out updated
bram_en_out  out  1  BRAM read enable (registered)
bram_addr_out  out  WW_WIDTH  BRAM read address (registered)
bram_data_in  in  SAMPLE_WIDTH  BRAM read data

Behaviour:
- Reset: slot counter 0; all sample outputs 0; valid pulses 0; bram_en_out 0, bram_addr_out 0; pending flags clear; tag pipe empty; rr pointer selects viz first.
- Slot counter runs 0..NUM_OSCILLATORS, wraps, and advances every cycle, including during load_busy_in. Frame = NUM_OSCILLATORS+1 cycles.
- Slot k < NUM_OSCILLATORS serves oscillator k using osc_index_in[k] sampled in that cycle.
- Slot NUM_OSCILLATORS is the aux slot:
  - both viz and dbg pending: grant the rr-pointer owner, then toggle the pointer;
  - one pending: grant it and leave the pointer unchanged;
  - none pending: idle, bram_en_out 0.
- Pending: a req pulse sets that requester's pending flag and latches its index.
  - A req arriving while already pending overwrites the index; the latest request wins and only one response is produced.
  - Grant clears pending. A req in the same cycle as its own grant re-sets pending with the new index; set wins.
- Issue: the slot decision in cycle t drives bram_en_out and bram_addr_out in cycle t+1.
  - The tag {valid, requester id, zero_flag} enters a BRAM_LATENCY+1 deep tag pipe.
  - Data is captured at the edge ending cycle t+1+BRAM_LATENCY, so outputs and valid pulses are visible in cycle t+2+BRAM_LATENCY (t+4 at default).
- Out-of-range index (index >= wave_width_in):
  - bram_en_out stays 0;
  - the tag still flows with zero_flag=1 and delivers sample 0 at the normal latency; aux requesters still get their valid pulse.
- wave_width_in = 0: every index is out of range and all deliveries are 0.
- load_busy_in high in a slot cycle:
  - no issue for that slot;
  - oscillator outputs hold their value;
  - aux pending flags are kept and the rr pointer is not advanced;
  - reads already in flight still complete and deliver.
- osc_sample_out[k] changes only on delivery of a slot-k tag. Valid pulses are never asserted for oscillators.
- Reset mid-operation: the tag pipe is flushed, so in-flight data is discarded and no valid pulse is emitted after reset.

Optional Feature:
ARB_STATS_EN.
- Defined: adds outputs stat_viz_grants_out, stat_dbg_grants_out and stat_stall_slots_out. Each is a 16-bit saturating counter (saturates at 0xFFFF) and is cleared by rst_in. stat_stall_slots_out counts slots lost to load_busy_in.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package wave_arb_pkg holds:
  - enum req_id_t {REQ_OSC, REQ_VIZ, REQ_DBG};
  - struct rd_tag_t {valid, req_id_t id, osc slot index, zero_flag};
  - localparam STAT_WIDTH = 16.
- Sub-module rd_tag_pipe: parameterized-depth shift register of rd_tag_t with synchronous flush. It is the natural split so the latency can be verified in isolation.

Test Plan:
- Reset, then osc_index_in = {10,20,30,40} with BRAM word = address: bram_addr_out shows 10,20,30,40 in cycles 1..4 and idles in cycle 5. osc_sample_out[0]=10 appears in cycle 4 after its slot decision.
- viz_req_in and dbg_req_in pulsed together (indices 100, 200): the first aux slot grants viz (viz_valid_out, sample 100). dbg is granted one frame later (sample 200), 5 cycles apart.
- viz_req_in index 7, then index 9 before grant: exactly one viz_valid_out, with sample 9.
- wave_width_in=50, osc index 60: bram_en_out stays low in that slot and osc_sample_out becomes 0. A dbg request with index 50 gives dbg_valid_out with sample 0.
- Pending dbg request, load_busy_in high for 12 cycles: no bram_en_out, and the dbg pending flag is retained. The grant occurs in the first aux slot after busy drops, with the correct sample.
- rst_in asserted 1 cycle after a viz grant: no viz_valid_out afterward, and all outputs read 0.
